// File: rtl/friscv_fifo_stream_pkg.sv
// ============================================================================
// friscv_fifo_stream_pkg : shared sizes for the FIFO stream output stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package friscv_fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;

  // Buffered word count, 0..BUF_DEPTH
  typedef logic [1:0] occ_t;

endpackage

`default_nettype wire

// File: rtl/friscv_fifo_stream_buf.sv
// ============================================================================
// friscv_fifo_stream_buf : 2-entry register buffer with wrapping pointers
// Revision: 1.0
// ============================================================================
`default_nettype none

module friscv_fifo_stream_buf
  import friscv_fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output occ_t                  occ_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  occ_t                  occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ wr_en_i;
    rd_ptr_d = rd_ptr_q ^ rd_en_i;
    occ_d    = occ_q + occ_t'(wr_en_i) - occ_t'(rd_en_i);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

  assign occ_o     = occ_q;
  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/friscv_fifo_stream_out.sv
// ============================================================================
// friscv_fifo_stream_out : FIFO pull control and valid/ready output stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module friscv_fifo_stream_out
  import friscv_fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  aclk,
  input  logic                  srst,
  output logic                  fifo_pull,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
);

  occ_t                  occ;
  logic                  pop;
  logic                  capture;
  logic                  inflight;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] buf_data;

  assign pop = m_valid & m_ready;

  // Counting in-flight words and this cycle's pop keeps occ+inflight <= 2
  assign pending   = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_pull = ~srst & ~fifo_empty & (pending < 3'(BUF_DEPTH));

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign capture  = fifo_pull;
      assign inflight = 1'b0;
    end else if (RD_LATENCY == 1) begin : g_lat1
      logic inflight_q;

      always_ff @(posedge aclk) begin
        if (srst) begin
          inflight_q <= 1'b0;
        end else begin
          inflight_q <= fifo_pull;
        end
      end

      assign capture  = inflight_q;
      assign inflight = inflight_q;
    end else begin : g_bad_latency
      $fatal(1, "friscv_fifo_stream_out: RD_LATENCY must be 0 or 1");
      assign capture  = 1'b0;
      assign inflight = 1'b0;
    end
  endgenerate

  friscv_fifo_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .aclk      (aclk),
    .srst      (srst),
    .wr_en_i   (capture),
    .wr_data_i (fifo_data),
    .rd_en_i   (pop),
    .occ_o     (occ),
    .rd_data_o (buf_data)
  );

  // Outputs are forced idle while reset is held, not only after it
  assign m_valid = (occ != '0) & ~srst;
  assign m_data  = srst ? '0 : buf_data;
  assign busy    = ((occ != '0) | inflight) & ~srst;

endmodule

`default_nettype wire

// File: tb/tb_friscv_fifo_stream_out.sv
// ============================================================================
// tb_friscv_fifo_stream_out : bench for both read latencies of the stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_friscv_fifo_stream_out;

  logic       clk = 1'b0;
  logic       srst;
  logic [1:0] pull, empty, valid, ready, busy;
  logic [7:0] fdata [2];
  logic [7:0] mdata [2];

  // Behavioural FIFOs feeding each instance
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] head0 = '0, head1 = '0;
  logic [7:0] tail0, tail1;
  logic [7:0] rd1 = '0;
  logic [7:0] expq0 [$];
  logic [7:0] expq1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  friscv_fifo_stream_out #(.DATA_WIDTH(8), .RD_LATENCY(0)) u_dut0 (
    .aclk(clk), .srst(srst), .fifo_pull(pull[0]), .fifo_empty(empty[0]),
    .fifo_data(fdata[0]), .m_valid(valid[0]), .m_ready(ready[0]),
    .m_data(mdata[0]), .busy(busy[0])
  );

  friscv_fifo_stream_out #(.DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .aclk(clk), .srst(srst), .fifo_pull(pull[1]), .fifo_empty(empty[1]),
    .fifo_data(fdata[1]), .m_valid(valid[1]), .m_ready(ready[1]),
    .m_data(mdata[1]), .busy(busy[1])
  );

  assign empty[0] = (head0 == tail0);
  assign empty[1] = (head1 == tail1);
  assign fdata[0] = mem0[head0];
  assign fdata[1] = rd1;

  always @(posedge clk) begin
    if (pull[0]) head0 <= head0 + 8'd1;
    if (pull[1]) begin
      head1 <= head1 + 8'd1;
      rd1   <= mem1[head1];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int k, input logic [7:0] d);
    logic [7:0] e;
    bit         have;
    have = 1'b0;
    e    = '0;
    if (k == 0 && expq0.size() != 0) begin e = expq0.pop_front(); have = 1'b1; end
    if (k == 1 && expq1.size() != 0) begin e = expq1.pop_front(); have = 1'b1; end
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL sb%0d_extra: got word %0h required no word", k, d);
    end else begin
      check($sformatf("sb%0d_order", k), int'(d), int'(e));
    end
  endtask

  // Stream scoreboard and hold-stability monitor, sampled mid-cycle
  logic [1:0] hold = '0;
  logic [7:0] hold_d [2];
  always @(negedge clk) begin
    if (srst) begin
      hold <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (hold[k]) begin
          check($sformatf("stable%0d_valid", k), int'(valid[k]), 1);
          check($sformatf("stable%0d_data", k), int'(mdata[k]), int'(hold_d[k]));
        end
        if (valid[k] && ready[k]) sb_pop(k, mdata[k]);
        hold[k]   <= valid[k] & ~ready[k];
        hold_d[k] <= mdata[k];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] v);
    if (k == 0) begin
      mem0[tail0] = v; tail0 = tail0 + 8'd1; expq0.push_back(v);
    end else begin
      mem1[tail1] = v; tail1 = tail1 + 8'd1; expq1.push_back(v);
    end
  endtask

  task automatic reset_start();
    srst  = 1'b1;
    ready = 2'b00;
    repeat (2) cyc();
    tail0 = head0;
    tail1 = head1;
    expq0.delete();
    expq1.delete();
  endtask

  typedef struct {
    int         inst;
    int         npre;
    logic [7:0] w0;
    logic [7:0] step;
    logic       rdy;
    logic       pull;
    logic       valid;
    logic       busy;
    logic       chkd;
    logic [7:0] data;
  } row_t;

  row_t rows [23];

  initial begin
    srst  = 1'b1;
    ready = 2'b00;
    tail0 = '0;
    tail1 = '0;

    // inst npre w0 step | rdy pull valid busy chkd data
    rows[0]  = '{1, 3, 8'h11, 8'h11, 1, 1, 0, 0, 0, 8'h00};
    rows[1]  = '{1, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'h00};
    rows[2]  = '{1, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h11};
    rows[3]  = '{1, 0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h22};
    rows[4]  = '{1, 0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h33};
    rows[5]  = '{1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00};
    rows[6]  = '{1, 5, 8'h51, 8'h01, 0, 1, 0, 0, 0, 8'h00};
    rows[7]  = '{1, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h00};
    rows[8]  = '{1, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 8'h51};
    rows[9]  = '{1, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 8'h51};
    rows[10] = '{1, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 8'h51};
    rows[11] = '{1, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h51};
    rows[12] = '{1, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h52};
    rows[13] = '{1, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h53};
    rows[14] = '{1, 0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h54};
    rows[15] = '{1, 0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h55};
    rows[16] = '{1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00};
    rows[17] = '{0, 4, 8'h31, 8'h01, 1, 1, 0, 0, 0, 8'h00};
    rows[18] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h31};
    rows[19] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h32};
    rows[20] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h33};
    rows[21] = '{0, 0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h34};
    rows[22] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00};

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_valid", k), int'(valid[k]), 0);
      check($sformatf("rst%0d_busy", k), int'(busy[k]), 0);
      check($sformatf("rst%0d_pull", k), int'(pull[k]), 0);
      check($sformatf("rst%0d_data", k), int'(mdata[k]), 0);
    end
    cyc();

    // Directed cycle tables: latency, throughput, backpressure
    for (int i = 0; i < 23; i++) begin
      if (rows[i].npre > 0) begin
        reset_start();
        for (int j = 0; j < rows[i].npre; j++)
          push(rows[i].inst, rows[i].w0 + 8'(j) * rows[i].step);
        srst = 1'b0;
      end
      ready = (rows[i].inst == 0) ? {1'b0, rows[i].rdy} : {rows[i].rdy, 1'b0};
      @(negedge clk);
      check($sformatf("row%0d_pull", i), int'(pull[rows[i].inst]), int'(rows[i].pull));
      check($sformatf("row%0d_valid", i), int'(valid[rows[i].inst]), int'(rows[i].valid));
      check($sformatf("row%0d_busy", i), int'(busy[rows[i].inst]), int'(rows[i].busy));
      if (rows[i].chkd)
        check($sformatf("row%0d_data", i), int'(mdata[rows[i].inst]), int'(rows[i].data));
      cyc();
    end

    // Latency 0, alternating ready over 8 words
    reset_start();
    for (int j = 0; j < 8; j++) push(0, 8'(j));
    srst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ready = {1'b0, (i % 2 == 0)};
      cyc();
    end
    check("alt_drained", expq0.size(), 0);

    // FIFO runs dry right after 0xA5
    reset_start();
    push(1, 8'hA4);
    push(1, 8'hA5);
    srst  = 1'b0;
    ready = 2'b10;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk);
        if (valid[1] && mdata[1] == 8'hA5) found = 1'b1;
        cyc();
      end
      check("a5_seen", int'(found), 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dry_valid", int'(valid[1]), 0);
      check("dry_busy", int'(busy[1]), 0);
      check("dry_pull", int'(pull[1]), 0);
      cyc();
    end

    // Reset with a full buffer, then a single fresh word
    reset_start();
    for (int j = 0; j < 5; j++) push(1, 8'h61 + 8'(j));
    srst = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("pre_rst_valid", int'(valid[1]), 1);
    check("pre_rst_pull", int'(pull[1]), 0);
    cyc();
    srst = 1'b1;
    @(negedge clk);
    check("in_rst_valid", int'(valid[1]), 0);
    check("in_rst_busy", int'(busy[1]), 0);
    check("in_rst_data", int'(mdata[1]), 0);
    check("in_rst_pull", int'(pull[1]), 0);
    tail1 = head1;
    expq1.delete();
    push(1, 8'h5A);
    cyc();
    srst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", int'(valid[1]), 0);
    check("post_rst_busy", int'(busy[1]), 0);
    check("post_rst_data", int'(mdata[1]), 0);
    cyc();
    ready = 2'b10;
    repeat (8) cyc();
    check("post_rst_drained", expq1.size(), 0);

    // Random traffic on both latencies against the scoreboard
    reset_start();
    srst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1 && 8'(tail0 - head0) < 8'd200) push(0, 8'($urandom));
      if ($urandom_range(1, 0) == 1 && 8'(tail1 - head1) < 8'd200) push(1, 8'($urandom));
      ready = {($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0)};
      cyc();
    end
    ready = 2'b11;
    for (int i = 0; i < 500 && (expq0.size() != 0 || expq1.size() != 0); i++) cyc();
    check("rand0_drained", expq0.size(), 0);
    check("rand1_drained", expq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
